// File: rtl/sa_ws_nxn_if.sv
// Handshake bundle for sa_ws_nxn: weight-row load, activation stream
// and result vector. master = buffer/driver side, slave = array side.
interface sa_ws_nxn_if #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int AW = 24
);
   logic            w_valid;
   logic            w_ready;
   logic [N*DW-1:0] w_row;
   logic            act_valid;
   logic            act_ready;
   logic [N*DW-1:0] act_in;
   logic            out_valid;
   logic [N*AW-1:0] psum_out;

   modport master (
      output w_valid, w_row, act_valid, act_in,
      input  w_ready, act_ready, out_valid, psum_out
   );

   modport slave (
      input  w_valid, w_row, act_valid, act_in,
      output w_ready, act_ready, out_valid, psum_out
   );
endinterface

// File: rtl/sa_ws_nxn.sv
// N x N weight-stationary systolic array, signed matrix-vector stream.
// Ports: clk, rst (sync high), clear (flush, weights kept), bus (slave).
module sa_ws_nxn #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int AW = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   sa_ws_nxn_if.slave  bus
);
   localparam int LAT = 2 * N;
   localparam int RW  = $clog2(N);
   localparam int CW  = $clog2(2 * N + 1);

   typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

   state_t          state, state_nx;
   logic [RW-1:0]   row_cnt, row_cnt_nx;
   logic [CW-1:0]   fly_cnt;
   logic            w_rdy, a_rdy;
   logic            w_fire, a_fire;

   logic signed [DW-1:0] w_q   [N][N];
   logic signed [DW-1:0] a_src [N];
   logic signed [DW-1:0] a_row [N];
   logic signed [DW-1:0] a_pe  [N][N];
   logic signed [DW-1:0] act_q [N][N-1];
   logic signed [AW-1:0] p_up  [N][N];
   logic signed [AW-1:0] prod  [N][N];
   logic signed [AW-1:0] ps_q  [N][N];
   logic signed [AW-1:0] dsk   [N];

   logic [LAT-2:0]  tag;
   logic            ov_q;
   logic [N*AW-1:0] po_q;

   assign w_fire = (state == LOAD) && bus.w_valid;
   assign a_fire = (state == RUN) && bus.act_valid
                   && !bus.w_valid && !clear;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= LOAD;
         row_cnt <= '0;
      end else begin
         state   <= state_nx;
         row_cnt <= row_cnt_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      row_cnt_nx = row_cnt;
      w_rdy      = 1'b0;
      a_rdy      = 1'b0;
      unique case (state)
         LOAD: begin
            w_rdy = 1'b1;
            if (w_fire) begin
               if (row_cnt == RW'(N - 1)) begin
                  state_nx   = RUN;
                  row_cnt_nx = '0;
               end else begin
                  row_cnt_nx = row_cnt + RW'(1);
               end
            end
         end
         RUN: begin
            // a pending weight reload blocks new vectors
            a_rdy = !bus.w_valid && !clear;
            if (bus.w_valid) state_nx = DRAIN;
         end
         DRAIN: begin
            if (clear || fly_cnt == '0) state_nx = LOAD;
         end
         default: state_nx = LOAD;
      endcase
   end

   assign bus.w_ready   = w_rdy;
   assign bus.act_ready = a_rdy;

   // ---------------- in-flight counter ----------------
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         fly_cnt <= '0;
      end else if (a_fire && !ov_q) begin
         fly_cnt <= fly_cnt + CW'(1);
      end else if (!a_fire && ov_q) begin
         fly_cnt <= fly_cnt - CW'(1);
      end
   end

   // ---------------- weight registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               w_q[r][c] <= '0;
      end else begin
         for (int r = 0; r < N; r++)
            if (w_fire && row_cnt == RW'(r))
               for (int c = 0; c < N; c++)
                  w_q[r][c] <= bus.w_row[c*DW +: DW];
      end
   end

   // ---------------- input skew ----------------
   genvar gi, gj;
   generate
      for (gi = 0; gi < N; gi++) begin : g_skew
         // idle cycles inject zeros so bubbles stay clean
         assign a_src[gi] = a_fire ? bus.act_in[gi*DW +: DW] : '0;
         if (gi == 0) begin : g_direct
            assign a_row[gi] = a_src[gi];
         end else begin : g_dly
            logic signed [DW-1:0] sk [gi];
            always_ff @(posedge clk) begin
               if (rst || clear) begin
                  for (int k = 0; k < gi; k++) sk[k] <= '0;
               end else begin
                  sk[0] <= a_src[gi];
                  for (int k = 1; k < gi; k++) sk[k] <= sk[k-1];
               end
            end
            assign a_row[gi] = sk[gi-1];
         end
      end
   endgenerate

   // ---------------- PE mesh ----------------
   generate
      for (gi = 0; gi < N; gi++) begin : g_row
         for (gj = 0; gj < N; gj++) begin : g_col
            logic signed [2*DW-1:0] m;
            if (gj == 0) begin : g_ain
               assign a_pe[gi][gj] = a_row[gi];
            end else begin : g_ash
               assign a_pe[gi][gj] = act_q[gi][gj-1];
            end
            if (gi == 0) begin : g_ptop
               assign p_up[gi][gj] = '0;
            end else begin : g_pdn
               assign p_up[gi][gj] = ps_q[gi-1][gj];
            end
            assign m = a_pe[gi][gj] * w_q[gi][gj];
            assign prod[gi][gj] = AW'(m);
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N - 1; c++) act_q[r][c] <= '0;
            for (int c = 0; c < N; c++)     ps_q[r][c]  <= '0;
         end
      end else begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N - 1; c++) act_q[r][c] <= a_pe[r][c];
            for (int c = 0; c < N; c++)
               ps_q[r][c] <= p_up[r][c] + prod[r][c];
         end
      end
   end

   // ---------------- output deskew ----------------
   generate
      for (gj = 0; gj < N; gj++) begin : g_dsk
         if (gj == N - 1) begin : g_last
            assign dsk[gj] = ps_q[N-1][gj];
         end else begin : g_dly
            logic signed [AW-1:0] d [N-1-gj];
            always_ff @(posedge clk) begin
               if (rst || clear) begin
                  for (int k = 0; k < N - 1 - gj; k++) d[k] <= '0;
               end else begin
                  d[0] <= ps_q[N-1][gj];
                  for (int k = 1; k < N - 1 - gj; k++) d[k] <= d[k-1];
               end
            end
            assign dsk[gj] = d[N-2-gj];
         end
      end
   endgenerate

   // valid tag travels 2N-1 stages, then the output register
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         tag  <= '0;
         ov_q <= 1'b0;
      end else begin
         tag  <= {tag[LAT-3:0], a_fire};
         ov_q <= tag[LAT-2];
      end
   end

   // result holds between pulses; flush does not erase it
   always_ff @(posedge clk) begin
      if (rst) begin
         po_q <= '0;
      end else if (tag[LAT-2] && !clear) begin
         for (int c = 0; c < N; c++) po_q[c*AW +: AW] <= dsk[c];
      end
   end

   assign bus.out_valid = ov_q;
   assign bus.psum_out  = po_q;
endmodule

// File: tb/tb_sa_ws_nxn.sv
// Directed + random bench for sa_ws_nxn against a matrix-vector model.
// Results are predicted per presentation cycle and checked every cycle.
module tb_sa_ws_nxn;
   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int AW  = 16;
   localparam int LAT = 2 * N;
   localparam int CKW = N * AW;

   typedef int vec_t [N];
   typedef struct {
      int              due;
      logic [N*AW-1:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear = 1'b0;

   sa_ws_nxn_if #(.N(N), .DW(DW), .AW(AW)) bus ();

   sa_ws_nxn #(.N(N), .DW(DW), .AW(AW)) dut (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   mrow = 0;
   int   W [N][N];
   exp_t q [$];
   vec_t zv = '{default: 0};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [N*DW-1:0] pack(vec_t v);
      logic [N*DW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = v[i][DW-1:0];
      return r;
   endfunction

   function automatic logic [N*AW-1:0] model_mv(vec_t a);
      logic [N*AW-1:0] r;
      r = '0;
      for (int j = 0; j < N; j++) begin
         int s;
         s = 0;
         for (int i = 0; i < N; i++) s += a[i] * W[i][j];
         r[j*AW +: AW] = s[AW-1:0];
      end
      return r;
   endfunction

   task automatic chk(string tag, logic [CKW-1:0] got,
                      logic [CKW-1:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s @cyc %0d: got %0h, expected %0h",
                tag, cyc, got, exp);
      end
   endtask

   // drops every predicted result the flush/reset edge will kill
   task automatic flush();
      while (q.size() > 0 && q[q.size()-1].due > cyc)
         void'(q.pop_back());
   endtask

   // one cycle: drive at posedge+1, check handshakes at negedge
   task automatic drive(bit rs, bit clr, bit wv, vec_t wr,
                        bit av, vec_t a, bit ewr, bit ear);
      @(posedge clk);
      #1;
      rst           = rs;
      clear         = clr;
      bus.w_valid   = wv;
      bus.w_row     = pack(wr);
      bus.act_valid = av;
      bus.act_in    = pack(a);
      if (rs || clr) flush();
      if (rs) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) W[i][j] = 0;
         mrow = 0;
      end else begin
         if (wv && ewr) begin
            W[mrow] = wr;
            mrow = (mrow + 1) % N;
         end
         if (av && ear) q.push_back('{cyc + LAT, model_mv(a)});
      end
      @(negedge clk);
      if (!rs) begin
         chk("w_ready", CKW'(bus.w_ready), CKW'(ewr));
         chk("act_ready", CKW'(bus.act_ready), CKW'(ear));
      end
   endtask

   task automatic idle_run(int n);
      for (int k = 0; k < n; k++) drive(0, 0, 0, zv, 0, zv, 0, 1);
   endtask

   task automatic rand_vec(output vec_t v);
      for (int i = 0; i < N; i++) v[i] = int'($urandom_range(255)) - 128;
   endtask

   // output monitor: pulse pattern and value against the model
   always @(negedge clk) begin
      logic ev;
      while (q.size() > 0 && q[0].due < cyc) begin
         chk("lost_result", CKW'(0), CKW'(1));
         void'(q.pop_front());
      end
      ev = (q.size() > 0 && q[0].due == cyc);
      chk("out_valid", CKW'(bus.out_valid), CKW'(ev));
      if (ev) begin
         chk("psum_out", bus.psum_out, q[0].val);
         void'(q.pop_front());
      end
   end

   initial begin
      vec_t a, wr;
      bus.w_valid   = 1'b0;
      bus.w_row     = '0;
      bus.act_valid = 1'b0;
      bus.act_in    = '0;

      // reset
      drive(1, 0, 0, zv, 0, zv, 0, 0);
      drive(1, 0, 0, zv, 0, zv, 0, 0);
      drive(0, 0, 0, zv, 0, zv, 1, 0);
      chk("psum_reset", bus.psum_out, '0);

      // identity weights, single vector
      for (int r = 0; r < N; r++) begin
         wr = zv;
         wr[r] = 1;
         drive(0, 0, 1, wr, 0, zv, 1, 0);
      end
      a = '{1, 2, 3, 4};
      drive(0, 0, 0, zv, 1, a, 0, 1);
      idle_run(LAT + 4);
      chk("ident_hold", bus.psum_out, 64'h0004_0003_0002_0001);

      // reload with W[i][j] = i+1, empty pipe: one DRAIN cycle
      drive(0, 0, 1, zv, 1, a, 0, 0);
      drive(0, 0, 1, zv, 0, zv, 0, 0);
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) wr[j] = r + 1;
         drive(0, 0, 1, wr, 0, zv, 1, 0);
      end

      // 16 back-to-back vectors, lane = 10k
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < N; i++) a[i] = k;
         drive(0, 0, 0, zv, 1, a, 0, 1);
      end
      idle_run(LAT + 2);
      chk("stream_hold", bus.psum_out, 64'h0096_0096_0096_0096);

      // reload request with 5 vectors in flight
      for (int k = 0; k < 5; k++) begin
         rand_vec(a);
         drive(0, 0, 0, zv, 1, a, 0, 1);
      end
      rand_vec(wr);
      drive(0, 0, 1, wr, 1, a, 0, 0);
      for (int k = 0; k < LAT; k++) drive(0, 0, 1, wr, 0, zv, 0, 0);
      for (int r = 0; r < N; r++) begin
         rand_vec(wr);
         drive(0, 0, 1, wr, 0, zv, 1, 0);
         if (r == 1) drive(0, 0, 0, zv, 0, zv, 1, 0);
      end
      rand_vec(a);
      drive(0, 0, 0, zv, 1, a, 0, 1);
      idle_run(LAT + 2);

      // signed wrap: weights -128
      drive(0, 0, 1, zv, 0, zv, 0, 0);
      drive(0, 0, 1, zv, 0, zv, 0, 0);
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) wr[j] = -128;
         drive(0, 0, 1, wr, 0, zv, 1, 0);
      end
      for (int i = 0; i < N; i++) a[i] = -128;
      drive(0, 0, 0, zv, 1, a, 0, 1);
      for (int i = 0; i < N; i++) a[i] = 127;
      drive(0, 0, 0, zv, 1, a, 0, 1);
      idle_run(LAT + 2);
      chk("wrap_hold", bus.psum_out, 64'h0200_0200_0200_0200);

      // clear two cycles after 3 accepts
      for (int k = 0; k < 3; k++) begin
         rand_vec(a);
         drive(0, 0, 0, zv, 1, a, 0, 1);
      end
      idle_run(1);
      drive(0, 1, 0, zv, 1, a, 0, 0);
      rand_vec(a);
      drive(0, 0, 0, zv, 1, a, 0, 1);
      idle_run(LAT + 2);

      // random traffic
      for (int k = 0; k < 40; k++) begin
         rand_vec(a);
         drive(0, 0, 0, zv, $urandom_range(1), a, 0, 1);
      end
      idle_run(LAT + 2);

      // reset in the middle of a load
      drive(0, 0, 1, zv, 0, zv, 0, 0);
      drive(0, 0, 1, zv, 0, zv, 0, 0);
      for (int r = 0; r < 2; r++) begin
         rand_vec(wr);
         drive(0, 0, 1, wr, 0, zv, 1, 0);
      end
      drive(1, 0, 0, zv, 0, zv, 0, 0);
      drive(0, 0, 0, zv, 0, zv, 1, 0);
      chk("psum_rst_mid", bus.psum_out, '0);
      for (int r = 0; r < N; r++) begin
         rand_vec(wr);
         drive(0, 0, 1, wr, 0, zv, 1, 0);
      end
      for (int k = 0; k < 3; k++) begin
         rand_vec(a);
         drive(0, 0, 0, zv, 1, a, 0, 1);
      end
      idle_run(LAT + 2);

      chk("pending_left", CKW'(q.size()), CKW'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sa_ws_nxn.md
# sa_ws_nxn

Parametrised N×N weight-stationary systolic array for signed int matrix-vector streaming. Internally skews incoming activation vectors, holds one weight per PE, and deskews column results so one complete output vector emerges per accepted input vector at a fixed latency. Sits between the activation/weight buffers and the output accumulator/writeback stage. It replaces hand-instantiated fixed-size arrays.

## Interface
- N, default 4: array rows = columns (≥2).
- DW, default 8: activation/weight width, signed two's complement.
- AW, default 24: partial-sum/output width, signed; must be ≥ 2*DW.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous pipeline flush; weights kept.
- w_valid  in  1  weight row beat offered.
- w_ready  out  1  weight row beat accepted when w_valid && w_ready.
- w_row  in  N*DW  one weight row; lane j in bits [j*DW +: DW] → PE(r,j).
- act_valid  in  1  activation vector offered.
- act_ready  out  1  vector accepted when act_valid && act_ready.
- act_in  in  N*DW  unskewed vector; lane i → array row i.
- out_valid  out  1  one-cycle pulse per result vector.
- psum_out  out  N*AW  result; lane j in bits [j*AW +: AW].

## Operation
- Result: psum_out[j] = Σ_i act_in[i] * W[i][j]. Products are 2*DW signed, sign-extended to AW, and summed modulo 2^AW (wrap, no saturation). Top-row psum input is 0.
- FSM states: LOAD, RUN, DRAIN. Reset enters LOAD with row counter = 0.
- LOAD:
  - w_ready=1, act_ready=0.
  - Each accepted beat writes row[counter] and increments the counter.
  - Accepting the N-th beat (counter N-1) → RUN; counter → 0.
- RUN:
  - w_ready=0.
  - act_ready = !w_valid. Weight-reload request takes priority; no vector is accepted in a cycle where w_valid=1.
  - w_valid=1 → DRAIN.
- DRAIN:
  - w_ready=0, act_ready=0.
  - Stays until the in-flight count is 0, then → LOAD.
  - If the count is already 0 on entry, it leaves after exactly one DRAIN cycle.
- In-flight count: +1 per accepted vector, −1 per out_valid; simultaneous ±1 leaves it unchanged. Maximum is 2N and it never overflows.
- Weights are held in PE registers and change only in LOAD. A vector accepted in RUN always uses the complete weight set loaded before entering RUN.
- Skew: row i activation delayed i cycles before PE(i,0). Each PE registers activation (rightward) and psum (downward).
- Deskew: column j delayed N-1-j cycles, plus one output register.
- No output backpressure; the consumer must accept every out_valid pulse.
- psum_out updates only on out_valid cycles and otherwise holds its last value.
- clear:
  - Zeroes skew, activation, psum, deskew and valid-tag registers; in-flight count → 0; out_valid=0 next cycle.
  - Weights, row counter and state are kept, except DRAIN → LOAD.
  - Vectors in flight are discarded. A vector offered during a clear cycle is not accepted (act_ready=0 while clear=1).
- rst priority over clear. rst mid-LOAD discards partially loaded rows.

## Timing
- Reset values:
  - state LOAD, counter 0, all weights 0, all pipeline registers 0.
  - out_valid=0, psum_out=0, w_ready=1, act_ready=0.
- Latency: vector accepted at edge t → out_valid=1 and psum_out valid in cycle t+2N (8 cycles for N=4).
- Throughput: one vector per cycle in RUN, sustained indefinitely; out_valid mirrors the accept pattern delayed 2N.
- Weight load: N consecutive beats minimum. Gaps (w_valid low) are allowed and stall the counter.
- RUN entered the cycle after the N-th beat. act_ready=1 in that cycle if w_valid=0.
- Reload overhead: DRAIN lasts until the last result has been output (≤2N cycles), then LOAD for N beats.

## Test plan
- Reset → w_ready=1, act_ready=0, out_valid=0, psum_out=0. Apply rst for 1 cycle mid-stream → same values next cycle, and weights read back as 0 (all-zero results after reload-free RUN are impossible; verify via a LOAD of 2 rows then rst then full load).
- N=4, identity weights; accept act_in={4,3,2,1} at t → out_valid at t+8 with psum_out={4,3,2,1}. No other out_valid pulse.
- N=4, W[i][j]=i+1; stream 16 back-to-back vectors, vector k = all lanes k → 16 consecutive out_valid pulses. Each lane = 10k; act_ready stays 1.
- Signed wrap with DW=8, AW=16, N=4: all weights −128, acts −128 → each lane 65536 mod 2^16 = 0. Acts 127, weights −128 → each lane −65024 wraps to 512.
- Reload: assert w_valid during a stream with 5 vectors in flight → act_ready=0 that cycle. The 5 results arrive with the old weights, then state LOAD with w_ready=1. After loading new weights, the next result uses the new weights.
- clear two cycles after accepting 3 vectors → no out_valid for them; weights retained. The next accepted vector returns the correct result at t+2N.
